slave_arbitrate_interface_wr_ddr_v2: RTL
========================================

Name: slave_arbitrate_interface_wr_ddr_v2

Overview:
Parametrised slave-side arbitration interface between a camera/ingress FIFO and the DDR write arbiter.
- Requests a DDR burst whenever the FIFO holds a full burst, and tracks the frame write offset.
- Flushes a partial tail burst at end of frame and applies bank ping-pong only at frame boundaries.
- Flags short frames and FIFO overflow.
- One instance per slave port; successor to the fixed 256-word, 18-bit-offset interface.

Parameters:
SLAVE_NUMBER, 4'b0000, slave ID field placed in the address.
SLAVE_ID_W, 4, width of the slave ID field.
PARAM_BIT, 1'b0, mode bit placed in the address.
BANK_W, 2, bank select width.
OFS_W, 18, frame offset width.
BURST_LEN, 256, full burst length in words; must be ≤ 2^(LEN_W-1).
LEN_W, 10, burst length port width.
MAX_ADDR, 245760, frame size in words; must be a multiple of BURST_LEN.
CNT_W, 11, FIFO level width.

Ports:
ddr_clk  in  1  clock
sys_rstn  in  1  asynchronous active-low reset
frame_start  in  1  1-cycle pulse at the start of a new frame (vsync negedge)
flush_req  in  1  1-cycle pulse: frame data fully written into the FIFO; drain the tail
fifo_full_flag  in  1  FIFO full
fifo_len  in  CNT_W  FIFO word count
slave_req  out  1  burst request to the arbiter
arbitrate_valid  in  1  grant; held high for the whole burst
slave_wr_load  in  1  bank-update strobe
slave_wrbank  in  BANK_W  next bank
slave_waddr  out  BANK_W+1+SLAVE_ID_W+OFS_W  concatenation {bank, PARAM_BIT, SLAVE_NUMBER, offset}
slave_wburst_len  out  LEN_W  length of the current burst
slave_frame_finished  out  1  frame fully written
frame_error  out  1  1-cycle pulse: short frame
overflow_flag  out  1  sticky FIFO-overflow flag

Behaviour:
Reset (async, sys_rstn low):
- All outputs are 0; slave_wburst_len = BURST_LEN.
- State = IDLE; bank_next = 0; bank_cur = 0; offset = 0; flush_pend = 0; start_pend = 0.

Bank handling:
- slave_wr_load captures slave_wrbank into bank_next.
- bank_cur <= bank_next only on an applied frame start, so a frame never straddles banks.

States: IDLE, REQ, BURST, DONE.
- IDLE -> REQ when !slave_frame_finished and one of:
  - fifo_len >= BURST_LEN, or
  - flush_pend and fifo_len > 0.
- On IDLE->REQ, latch slave_wburst_len:
  - BURST_LEN if fifo_len >= BURST_LEN;
  - otherwise min(fifo_len, MAX_ADDR - offset).
- REQ:
  - slave_req = 1 from the cycle after entry.
  - On arbitrate_valid = 1: clear slave_req on the next edge; go to BURST.
- BURST:
  - Exit on the first cycle arbitrate_valid is sampled 0 (grant falling edge).
  - On that edge: offset <= offset + slave_wburst_len.
  - If the new offset == MAX_ADDR: slave_frame_finished <= 1, flush_pend <= 0, go to DONE.
  - If it was a partial (flush) burst: flush_pend <= 0, go to IDLE.
  - Otherwise go to IDLE.
- DONE: slave_req is held 0 until an applied frame start.

Address and width rules:
- slave_waddr is combinational from bank_cur and the registered offset. It is stable during REQ and BURST.
- Offset arithmetic is OFS_W bits with no wrap. Offset is never incremented past MAX_ADDR.

fifo_full_flag:
- Sampled high in IDLE or DONE: overflow_flag <= 1.
- Sampled high in IDLE with !slave_frame_finished: forces an IDLE->REQ request, regardless of fifo_len.

flush_req:
- Sets flush_pend.
- Ignored when slave_frame_finished = 1.

frame_start applied (in IDLE, REQ or DONE):
- Same edge: offset <= 0, slave_frame_finished <= 0, flush_pend <= 0, overflow_flag <= 0, bank_cur <= bank_next, state <= IDLE, slave_req <= 0.
- frame_error pulses if the old offset was neither 0 nor MAX_ADDR.

frame_start during BURST:
- Sets start_pend; the burst completes normally.
- The frame start is applied on the edge after BURST exit.

Simultaneous events:
- frame_start and a grant falling edge on the same cycle: the offset update happens first; the frame start is applied on the next edge.
- flush_req with frame_start: frame_start wins.

Spurious arbitrate_valid (outside REQ and BURST): ignored, no state change.

Decomposition:
- Shared package: state encoding (IDLE/REQ/BURST/DONE), the address field-width helper function, and default BURST_LEN and MAX_ADDR constants.
- Sub-module: slave_wr_frame_tracker, containing the offset counter, finished/error/start_pend logic and bank_cur.
- The FSM and request logic stay in the top level.

Test Plan:
1. Full burst: fifo_len = 256 in IDLE -> slave_req = 1, 2 cycles later. Grant held 256 cycles; on falling edge, slave_waddr offset = 256, slave_wburst_len = 256.
2. Frame completion: 960 bursts -> offset 245760, slave_frame_finished = 1. Further fifo_len = 300 -> no slave_req. frame_start -> offset 0, finished 0, frame_error stays 0.
3. Tail flush: offset 245504, fifo_len = 100, flush_req -> slave_wburst_len = 100. After the grant, offset = 245604, flush_pend = 0, not finished. Then frame_start -> frame_error pulse.
4. Bank ping-pong: slave_wr_load with bank 2'b01 mid-frame -> slave_waddr[24:23] stays 00 until frame_start, then reads 01.
5. frame_start during BURST -> the burst finishes and offset advances by 256. The next cycle offset = 0 and frame_error = 1.
6. Overflow: fifo_full_flag in IDLE with fifo_len = 10 -> overflow_flag = 1 and slave_req = 1. Async reset asserted mid-burst -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/slave_arbitrate_interface_wr_ddr_v2_pkg.sv
// Shared definitions for the slave-side DDR write arbitration interface:
// FSM state encoding, address width helper and default frame geometry.
package slave_arbitrate_interface_wr_ddr_v2_pkg;

   // Request FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_BURST = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Default burst length in words and frame size in words
   localparam int DEFAULT_BURST_LEN = 256;
   localparam int DEFAULT_MAX_ADDR  = 245760;

   // Width of the DDR write address {bank, mode bit, slave id, offset}
   function automatic int addrWidth(input int bankW, input int slaveIdW, input int ofsW);
      return bankW + 1 + slaveIdW + ofsW;
   endfunction

endpackage

// File: rtl/slave_wr_frame_tracker.sv
// Frame bookkeeping for one slave port: write offset, frame-finished flag,
// short-frame error pulse, deferred frame start and bank ping-pong.
module slave_wr_frame_tracker #(
   parameter int BANK_W   = 2,
   parameter int OFS_W    = 18,
   parameter int LEN_W    = 10,
   parameter int MAX_ADDR = 245760
) (
   input  logic              i_ddr_clk,
   input  logic              i_sys_rstn,
   input  logic              i_frameStart,
   input  logic              i_inBurst,
   input  logic              i_grantFall,
   input  logic [LEN_W-1:0]  i_burstLen,
   input  logic              i_slaveWrLoad,
   input  logic [BANK_W-1:0] i_slaveWrbank,
   output logic              o_applyStart,
   output logic              o_reachEnd,
   output logic [OFS_W-1:0]  o_offset,
   output logic [BANK_W-1:0] o_bankCur,
   output logic              o_finished,
   output logic              o_frameError
);

   localparam logic [31:0] MAX32 = 32'(MAX_ADDR);

   logic [OFS_W-1:0]  r_offset;
   logic [BANK_W-1:0] r_bankNext;
   logic [BANK_W-1:0] r_bankCur;
   logic              r_finished;
   logic              r_frameError;
   logic              r_startPend;
   logic [31:0]       w_sum;
   logic [31:0]       w_sumSat;

   // Offset after the current burst, saturated so a frame never overruns MAX_ADDR
   always_comb begin
      w_sum    = 32'(r_offset) + 32'(i_burstLen);
      w_sumSat = w_sum;
      if (w_sum > MAX32) begin
         w_sumSat = MAX32;
      end
   end

   // A frame start is never applied mid-burst; it waits in r_startPend instead
   assign o_applyStart = !i_inBurst && (i_frameStart || r_startPend);
   assign o_reachEnd   = (w_sumSat == MAX32);
   assign o_offset     = r_offset;
   assign o_bankCur    = r_bankCur;
   assign o_finished   = r_finished;
   assign o_frameError = r_frameError;

   // Offset, finished/error flags and bank switching at frame boundaries only
   always_ff @(posedge i_ddr_clk or negedge i_sys_rstn) begin
      if (!i_sys_rstn) begin
         r_offset     <= '0;
         r_bankNext   <= '0;
         r_bankCur    <= '0;
         r_finished   <= 1'b0;
         r_frameError <= 1'b0;
         r_startPend  <= 1'b0;
      end else begin
         if (i_slaveWrLoad) begin
            r_bankNext <= i_slaveWrbank;
         end
         if (o_applyStart) begin
            r_offset     <= '0;
            r_finished   <= 1'b0;
            r_bankCur    <= r_bankNext;
            r_startPend  <= 1'b0;
            r_frameError <= (r_offset != '0) && (32'(r_offset) != MAX32);
         end else begin
            r_frameError <= 1'b0;
            if (i_inBurst && i_frameStart) begin
               r_startPend <= 1'b1;
            end
            if (i_grantFall) begin
               r_offset <= OFS_W'(w_sumSat);
               if (o_reachEnd) begin
                  r_finished <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/slave_arbitrate_interface_wr_ddr_v2.sv
// Slave-side arbitration interface between an ingress FIFO and the DDR write
// arbiter: requests bursts, flushes the frame tail and flags overflow.
module slave_arbitrate_interface_wr_ddr_v2
   import slave_arbitrate_interface_wr_ddr_v2_pkg::*;
#(
   parameter int                    SLAVE_ID_W   = 4,
   parameter logic [SLAVE_ID_W-1:0] SLAVE_NUMBER = '0,
   parameter logic                  PARAM_BIT    = 1'b0,
   parameter int                    BANK_W       = 2,
   parameter int                    OFS_W        = 18,
   parameter int                    BURST_LEN    = DEFAULT_BURST_LEN,
   parameter int                    LEN_W        = 10,
   parameter int                    MAX_ADDR     = DEFAULT_MAX_ADDR,
   parameter int                    CNT_W        = 11
) (
   input  logic                  i_ddr_clk,
   input  logic                  i_sys_rstn,
   input  logic                  i_frame_start,
   input  logic                  i_flush_req,
   input  logic                  i_fifo_full_flag,
   input  logic [CNT_W-1:0]      i_fifo_len,
   output logic                  o_slave_req,
   input  logic                  i_arbitrate_valid,
   input  logic                  i_slave_wr_load,
   input  logic [BANK_W-1:0]     i_slave_wrbank,
   output logic [addrWidth(BANK_W, SLAVE_ID_W, OFS_W)-1:0] o_slave_waddr,
   output logic [LEN_W-1:0]      o_slave_wburst_len,
   output logic                  o_slave_frame_finished,
   output logic                  o_frame_error,
   output logic                  o_overflow_flag
);

   localparam logic [31:0] BL32  = 32'(BURST_LEN);
   localparam logic [31:0] MAX32 = 32'(MAX_ADDR);

   state_t            r_state;
   state_t            w_stateNext;
   logic              r_slaveReq;
   logic [LEN_W-1:0]  r_burstLen;
   logic              r_partial;
   logic              r_flushPend;
   logic              r_overflow;

   logic              w_inBurst;
   logic              w_grantFall;
   logic              w_applyStart;
   logic              w_reachEnd;
   logic [OFS_W-1:0]  w_offset;
   logic [BANK_W-1:0] w_bankCur;
   logic              w_finished;
   logic              w_frameError;
   logic [31:0]       w_fifo32;
   logic [31:0]       w_lenCand;
   logic              w_fullBurst;
   logic              w_reqCond;
   logic              w_startReq;

   assign w_inBurst   = (r_state == ST_BURST);
   assign w_grantFall = w_inBurst && !i_arbitrate_valid;

   slave_wr_frame_tracker #(
      .BANK_W   (BANK_W),
      .OFS_W    (OFS_W),
      .LEN_W    (LEN_W),
      .MAX_ADDR (MAX_ADDR)
   ) u_tracker (
      .i_ddr_clk     (i_ddr_clk),
      .i_sys_rstn    (i_sys_rstn),
      .i_frameStart  (i_frame_start),
      .i_inBurst     (w_inBurst),
      .i_grantFall   (w_grantFall),
      .i_burstLen    (r_burstLen),
      .i_slaveWrLoad (i_slave_wr_load),
      .i_slaveWrbank (i_slave_wrbank),
      .o_applyStart  (w_applyStart),
      .o_reachEnd    (w_reachEnd),
      .o_offset      (w_offset),
      .o_bankCur     (w_bankCur),
      .o_finished    (w_finished),
      .o_frameError  (w_frameError)
   );

   // Burst length to latch: a full burst when available, else the FIFO level,
   // never more than the words left in the frame
   always_comb begin
      w_fifo32    = 32'(i_fifo_len);
      w_fullBurst = (w_fifo32 >= BL32);
      w_lenCand   = w_fullBurst ? BL32 : w_fifo32;
      if (w_lenCand > (MAX32 - 32'(w_offset))) begin
         w_lenCand = MAX32 - 32'(w_offset);
      end
      w_reqCond = !w_finished &&
                  (w_fullBurst || (r_flushPend && (w_fifo32 != 32'd0)) || i_fifo_full_flag);
   end

   // Next-state logic; an applied frame start always returns to IDLE
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_applyStart) begin
               w_stateNext = ST_IDLE;
            end else if (w_reqCond) begin
               w_stateNext = ST_REQ;
            end
         end
         ST_REQ: begin
            if (w_applyStart) begin
               w_stateNext = ST_IDLE;
            end else if (i_arbitrate_valid) begin
               w_stateNext = ST_BURST;
            end
         end
         ST_BURST: begin
            if (!i_arbitrate_valid) begin
               w_stateNext = w_reachEnd ? ST_DONE : ST_IDLE;
            end
         end
         ST_DONE: begin
            if (w_applyStart) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
      w_startReq = (r_state == ST_IDLE) && (w_stateNext == ST_REQ);
   end

   // State register
   always_ff @(posedge i_ddr_clk or negedge i_sys_rstn) begin
      if (!i_sys_rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Request strobe, latched burst length, pending flush and sticky overflow
   always_ff @(posedge i_ddr_clk or negedge i_sys_rstn) begin
      if (!i_sys_rstn) begin
         r_slaveReq  <= 1'b0;
         r_burstLen  <= LEN_W'(BURST_LEN);
         r_partial   <= 1'b0;
         r_flushPend <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_slaveReq <= (r_state == ST_REQ) && (w_stateNext == ST_REQ);
         if (w_startReq) begin
            r_burstLen <= LEN_W'(w_lenCand);
            r_partial  <= !w_fullBurst;
         end
         if (w_applyStart) begin
            r_flushPend <= 1'b0;
         end else if (w_grantFall && (r_partial || w_reachEnd)) begin
            r_flushPend <= 1'b0;
         end else if (i_flush_req && !w_finished) begin
            r_flushPend <= 1'b1;
         end
         if (w_applyStart) begin
            r_overflow <= 1'b0;
         end else if (i_fifo_full_flag && ((r_state == ST_IDLE) || (r_state == ST_DONE))) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_slave_req            = r_slaveReq;
   assign o_slave_waddr          = {w_bankCur, PARAM_BIT, SLAVE_NUMBER, w_offset};
   assign o_slave_wburst_len     = r_burstLen;
   assign o_slave_frame_finished = w_finished;
   assign o_frame_error          = w_frameError;
   assign o_overflow_flag        = r_overflow;

endmodule
